// File: rtl/crg_triple_streamer_pkg.sv
// Shared types for the CRG triple streamer: share/counter types, beat kinds,
// the buffered triple record and the streamer FSM state encoding.
package crg_triple_streamer_pkg;

  typedef logic [255:0] prng_t;
  typedef logic [31:0]  cr_cnt_t;

  typedef enum logic [1:0] {BEAT_A, BEAT_B, BEAT_C, BEAT_E} beat_kind_t;

  typedef struct packed {
    prng_t      a;
    prng_t      b;
    prng_t      c;
    logic [7:0] e;
  } triple_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_ISSUE, ST_DRAIN} strm_state_t;

endpackage

// File: rtl/crg_triple_streamer_if.sv
// 256-bit valid/ready beat stream from the triple streamer toward the MPC engine.
interface crg_triple_streamer_if;
  import crg_triple_streamer_pkg::*;

  prng_t      tdata;
  logic [1:0] tuser;
  logic       tlast;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);

endinterface

// File: rtl/crg_triple_streamer_triple_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; DEPTH must be a
// power of two.
module crg_triple_streamer_triple_fifo #(
  parameter int unsigned WIDTH = 768,
  parameter int unsigned DEPTH = 512
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_FULL) || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/crg_triple_streamer.sv
// Issues credit-checked counter bursts to CRG, buffers returned triples and
// serialises them as a/b/c(/e) beats. Macro CRG_STREAM_E_BEAT_EN enables the e beat.
//
// state     | meaning
// ST_IDLE   | ready for a request
// ST_CREDIT | waiting for zero outstanding and FIFO room for the next burst
// ST_ISSUE  | run pulse to CRG, burst bookkeeping
// ST_DRAIN  | waiting for all results to be streamed out, then done pulse
module crg_triple_streamer
  import crg_triple_streamer_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned BURST = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  cr_cnt_t     req_cnt_start_i,
  input  logic [31:0] req_num_i,
  input  logic        req_ext_i,
  output logic        done_o,
  output logic        err_o,
  output logic        crg_run_o,
  output cr_cnt_t     crg_cnt_start_o,
  output cr_cnt_t     crg_cnt_end_o,
  input  prng_t       crg_a_i,
  input  prng_t       crg_b_i,
  input  prng_t       crg_c_i,
  input  logic [7:0]  crg_e_i,
  input  logic        crg_dvld_i,
  crg_triple_streamer_if.master m_if
);
`ifdef CRG_STREAM_E_BEAT_EN
  localparam int unsigned FW = $bits(triple_t);
`else
  localparam int unsigned FW = $bits(triple_t) - 8;
`endif
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  strm_state_t state_q, state_d;
  cr_cnt_t     cur_q, cur_d, start_q, start_d, end_q, end_d;
  logic [31:0] rem_q, rem_d, n_q, n_d, out_q, out_d, emit_q, emit_d;
  beat_kind_t  beat_q, beat_d, last_beat;
  logic        done_q, done_d, err_q, err_d;
  logic        push, pop;
  logic [32:0] room, n_calc, free;
  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic [CW-1:0] fifo_cnt;
  triple_t     rd_t;
  prng_t       beat_data;

`ifdef CRG_STREAM_E_BEAT_EN
  logic ext_q, ext_d;
  assign fifo_wdata = {crg_a_i, crg_b_i, crg_c_i, crg_e_i};
  assign rd_t       = fifo_rdata;
  assign last_beat  = ext_q ? BEAT_E : BEAT_C;
`else
  logic unused_ext;
  assign unused_ext = ^{req_ext_i, crg_e_i};
  assign fifo_wdata = {crg_a_i, crg_b_i, crg_c_i};
  assign rd_t       = {fifo_rdata, 8'h00};
  assign last_beat  = BEAT_C;
`endif

  crg_triple_streamer_triple_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt)
  );

  always_comb begin
    beat_data = rd_t.a;
    case (beat_q)
      BEAT_B:  beat_data = rd_t.b;
      BEAT_C:  beat_data = rd_t.c;
      BEAT_E:  beat_data = {248'h0, rd_t.e};
      default: beat_data = rd_t.a;
    endcase
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign crg_run_o       = (state_q == ST_ISSUE);
  assign crg_cnt_start_o = start_q;
  assign crg_cnt_end_o   = end_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign m_if.tvalid     = (fifo_cnt != '0);
  assign m_if.tdata      = m_if.tvalid ? beat_data : '0;
  assign m_if.tuser      = beat_q;
  assign m_if.tlast      = m_if.tvalid && (beat_q == last_beat) && (emit_q == 32'd1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    n_d     = n_q;
    start_d = start_q;
    end_d   = end_q;
    out_d   = out_q;
    emit_d  = emit_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
`ifdef CRG_STREAM_E_BEAT_EN
    ext_d   = ext_q;
`endif
    push    = crg_dvld_i && (out_q != '0);
    err_d   = err_q | (crg_dvld_i && (out_q == '0));
    pop     = 1'b0;
    // Burst size is also capped at the counter wrap so CRG always sees E >= S.
    room    = 33'h1_0000_0000 - {1'b0, cur_q};
    n_calc  = {1'b0, rem_q};
    if (n_calc > 33'(BURST)) n_calc = 33'(BURST);
    if (n_calc > room)       n_calc = room;
    free    = 33'(DEPTH) - 33'(fifo_cnt);

    if (push) out_d = out_q - 32'd1;

    if (m_if.tvalid && m_if.tready) begin
      if (beat_q == last_beat) begin
        beat_d = BEAT_A;
        pop    = 1'b1;
        emit_d = emit_q - 32'd1;
      end else begin
        beat_d = beat_kind_t'(beat_q + 2'd1);
      end
    end

    case (state_q)
      ST_IDLE: if (req_valid_i) begin
        cur_d   = req_cnt_start_i;
        rem_d   = req_num_i;
        emit_d  = req_num_i;
`ifdef CRG_STREAM_E_BEAT_EN
        ext_d   = req_ext_i;
`endif
        state_d = (req_num_i != '0) ? ST_CREDIT : ST_DRAIN;
      end
      ST_CREDIT: if ((out_q == '0) && (free >= n_calc)) begin
        start_d = cur_q;
        end_d   = cur_q + n_calc[31:0] - 32'd1;
        n_d     = n_calc[31:0];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        out_d   = n_q;
        cur_d   = cur_q + n_q;
        rem_d   = rem_q - n_q;
        state_d = (rem_q == n_q) ? ST_DRAIN : ST_CREDIT;
      end
      ST_DRAIN: if ((out_q == '0) && (fifo_cnt == '0)) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      start_q <= '0;
      end_q   <= '0;
      out_q   <= '0;
      emit_q  <= '0;
      beat_q  <= BEAT_A;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CRG_STREAM_E_BEAT_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      start_q <= start_d;
      end_q   <= end_d;
      out_q   <= out_d;
      emit_q  <= emit_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CRG_STREAM_E_BEAT_EN
      ext_q   <= ext_d;
`endif
    end
  end

endmodule

// File: tb/tb_crg_triple_streamer.sv
// Self-checking bench for crg_triple_streamer: behavioural CRG, beat scoreboard,
// request vector table and hand-written reset / zero-length sequences.
`timescale 1ns/1ps
module tb_crg_triple_streamer;
  import crg_triple_streamer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i, req_ready_o, req_ext_i;
  cr_cnt_t     req_cnt_start_i;
  logic [31:0] req_num_i;
  logic        done_o, err_o, crg_run_o, crg_dvld_i;
  cr_cnt_t     crg_cnt_start_o, crg_cnt_end_o;
  prng_t       crg_a_i, crg_b_i, crg_c_i;
  logic [7:0]  crg_e_i;

  always #5 clk_i = ~clk_i;

  crg_triple_streamer_if m_if();

  crg_triple_streamer dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_cnt_start_i (req_cnt_start_i),
    .req_num_i       (req_num_i),
    .req_ext_i       (req_ext_i),
    .done_o          (done_o),
    .err_o           (err_o),
    .crg_run_o       (crg_run_o),
    .crg_cnt_start_o (crg_cnt_start_o),
    .crg_cnt_end_o   (crg_cnt_end_o),
    .crg_a_i         (crg_a_i),
    .crg_b_i         (crg_b_i),
    .crg_c_i         (crg_c_i),
    .crg_e_i         (crg_e_i),
    .crg_dvld_i      (crg_dvld_i),
    .m_if            (m_if)
  );

  typedef struct {prng_t data; int user; logic last;} beat_t;
  typedef struct {cr_cnt_t s; cr_cnt_t e;} run_t;
  typedef struct {cr_cnt_t s; logic [31:0] n; logic ext; int pct; int beats; int runs;} vec_t;

  beat_t   sb_q[$];
  run_t    run_q[$];
  cr_cnt_t crg_q[$];
  int      checks = 0, failures = 0;
  int      beats_seen = 0, runs_seen = 0, done_seen = 0, ready_pct = 100;
  logic    cur_ext = 1'b0;
  cr_cnt_t last_cnt = '0;

  function automatic prng_t fa(cr_cnt_t c); return {8{c ^ 32'hA5A5_5A5A}}; endfunction
  function automatic prng_t fb(cr_cnt_t c); return {4{c, ~c}}; endfunction
  function automatic prng_t fc(cr_cnt_t c); return {8{c + 32'h0F0F_0F0F}}; endfunction
  function automatic logic [7:0] fe(cr_cnt_t c); return c[7:0] ^ 8'h3C; endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input prng_t act, input prng_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_req_ready"}, int'(req_ready_o), 1);
    chk({p, "_done"}, int'(done_o), 0);
    chk({p, "_err"}, int'(err_o), 0);
    chk({p, "_run"}, int'(crg_run_o), 0);
    chk({p, "_cnt_start"}, int'(crg_cnt_start_o), 0);
    chk({p, "_cnt_end"}, int'(crg_cnt_end_o), 0);
    chk({p, "_tvalid"}, int'(m_if.tvalid), 0);
    chk({p, "_tuser"}, int'(m_if.tuser), 0);
    chk({p, "_tlast"}, int'(m_if.tlast), 0);
    chk_d({p, "_tdata"}, m_if.tdata, '0);
  endtask

  // Independent model of the burst split: BURST = 256, split at counter wrap.
  task automatic build_runs(input cr_cnt_t s, input logic [31:0] n, input logic ext);
    cr_cnt_t     cur;
    logic [31:0] rem;
    logic [32:0] k, room;
    run_q.delete();
    sb_q.delete();
    cur = s;
    rem = n;
    while (rem != 0) begin
      k    = (rem > 32'd256) ? 33'd256 : {1'b0, rem};
      room = 33'h1_0000_0000 - {1'b0, cur};
      if (k > room) k = room;
      run_q.push_back('{cur, cur + k[31:0] - 32'd1});
      cur = cur + k[31:0];
      rem = rem - k[31:0];
    end
    last_cnt   = s + n - 32'd1;
    cur_ext    = ext;
    beats_seen = 0;
    runs_seen  = 0;
    done_seen  = 0;
  endtask

  // Behavioural CRG plus random sink ready; pushes expected beats as data is driven.
  initial begin
    int      delay;
    int      nb;
    cr_cnt_t c;
    run_t    r;
    beat_t   bt;
    logic    ext_en;
    delay = 0;
    crg_dvld_i = 1'b0;
    crg_a_i = '0; crg_b_i = '0; crg_c_i = '0; crg_e_i = '0;
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      crg_dvld_i  = 1'b0;
      m_if.tready = (int'($urandom_range(99)) < ready_pct);
      if (!rst_n_i) begin
        crg_q.delete();
        delay = 0;
        continue;
      end
      if (crg_run_o) begin
        runs_seen++;
        chk("run_while_outstanding", crg_q.size(), 0);
        chk("run_expected", int'(run_q.size() != 0), 1);
        if (run_q.size() != 0) begin
          r = run_q.pop_front();
          chk("run_start", int'(crg_cnt_start_o), int'(r.s));
          chk("run_end", int'(crg_cnt_end_o), int'(r.e));
        end
        for (int unsigned k = 0; k <= 32'(crg_cnt_end_o - crg_cnt_start_o); k++)
          crg_q.push_back(crg_cnt_start_o + k);
        delay = 2;
      end
      if (delay > 0) delay--;
      else if (crg_q.size() != 0) begin
        c = crg_q.pop_front();
        crg_a_i = fa(c); crg_b_i = fb(c); crg_c_i = fc(c); crg_e_i = fe(c);
        crg_dvld_i = 1'b1;
`ifdef CRG_STREAM_E_BEAT_EN
        ext_en = cur_ext;
`else
        ext_en = 1'b0;
`endif
        nb = ext_en ? 4 : 3;
        for (int j = 0; j < nb; j++) begin
          bt.user = j;
          bt.data = (j == 0) ? fa(c) : (j == 1) ? fb(c) : (j == 2) ? fc(c) : {248'h0, fe(c)};
          bt.last = (c == last_cnt) && (j == nb - 1);
          sb_q.push_back(bt);
        end
      end
    end
  end

  // Stream monitor: stall stability plus scoreboard compare on each handshake.
  initial begin
    beat_t      ex;
    logic       stall_prev;
    prng_t      d_prev;
    logic [1:0] u_prev;
    logic       l_prev;
    stall_prev = 1'b0;
    d_prev = '0; u_prev = '0; l_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        stall_prev = 1'b0;
        continue;
      end
      if (done_o) done_seen++;
      if (stall_prev) begin
        chk("hold_tvalid", int'(m_if.tvalid), 1);
        chk_d("hold_tdata", m_if.tdata, d_prev);
        chk("hold_tuser", int'(m_if.tuser), int'(u_prev));
        chk("hold_tlast", int'(m_if.tlast), int'(l_prev));
      end
      if (m_if.tvalid && m_if.tready) begin
        beats_seen++;
        chk("beat_expected", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          ex = sb_q.pop_front();
          chk_d("beat_tdata", m_if.tdata, ex.data);
          chk("beat_tuser", int'(m_if.tuser), ex.user);
          chk("beat_tlast", int'(m_if.tlast), int'(ex.last));
        end
      end
      stall_prev = m_if.tvalid && !m_if.tready;
      d_prev = m_if.tdata;
      u_prev = m_if.tuser;
      l_prev = m_if.tlast;
    end
  end

  task automatic drive_req(input cr_cnt_t s, input logic [31:0] n, input logic ext);
    @(negedge clk_i);
    chk("req_ready_before_accept", int'(req_ready_o), 1);
    req_valid_i = 1'b1; req_cnt_start_i = s; req_num_i = n; req_ext_i = ext;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic run_req(input string name, input vec_t v);
    int cyc;
    build_runs(v.s, v.n, v.ext);
    ready_pct = v.pct;
    drive_req(v.s, v.n, v.ext);
    cyc = 0;
    while (done_seen == 0 && cyc < 40000) begin
      @(negedge clk_i);
      cyc++;
    end
    repeat (5) @(negedge clk_i);
    chk({name, "_done_in_time"}, int'(cyc < 40000), 1);
    chk({name, "_done_count"}, done_seen, 1);
    chk({name, "_beats"}, beats_seen, v.beats);
    chk({name, "_runs"}, runs_seen, v.runs);
    chk({name, "_sb_left"}, sb_q.size(), 0);
    chk({name, "_runs_left"}, run_q.size(), 0);
    chk({name, "_err"}, int'(err_o), 0);
    chk({name, "_ready_after"}, int'(req_ready_o), 1);
    ready_pct = 100;
  endtask

  vec_t vecs[6];

  initial begin
    req_valid_i = 1'b0; req_cnt_start_i = '0; req_num_i = '0; req_ext_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_vals("por");
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    vecs[0] = '{32'd3,          32'd10,   1'b0, 100, 30,   1};
    vecs[1] = '{32'd0,          32'd600,  1'b0, 100, 1800, 3};
    vecs[2] = '{32'hFFFF_FFFE,  32'd5,    1'b0, 100, 15,   2};
    vecs[3] = '{32'd100,        32'd1000, 1'b0, 30,  3000, 4};
`ifdef CRG_STREAM_E_BEAT_EN
    vecs[4] = '{32'h0000_1000,  32'd4,    1'b1, 50,  16,   1};
`else
    vecs[4] = '{32'h0000_1000,  32'd4,    1'b1, 50,  12,   1};
`endif
    vecs[5] = '{32'h1234_5678,  32'd0,    1'b0, 100, 0,    0};

    for (int i = 0; i < 6; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Zero-length request: done exactly two cycles after the accept edge.
    build_runs(32'd9, 32'd0, 1'b0);
    drive_req(32'd9, 32'd0, 1'b0);
    @(negedge clk_i);
    chk("zero_done_c1", int'(done_o), 0);
    @(negedge clk_i);
    chk("zero_done_c2", int'(done_o), 1);
    chk("zero_ready_c2", int'(req_ready_o), 1);
    @(negedge clk_i);
    chk("zero_done_c3", int'(done_o), 0);
    chk("zero_runs", runs_seen, 0);

    // Reset in the middle of a burst, then a clean request.
    build_runs(32'h50, 32'd600, 1'b0);
    drive_req(32'h50, 32'd600, 1'b0);
    repeat (150) @(negedge clk_i);
    chk("midrst_busy", int'(req_ready_o), 0);
    rst_n_i = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (3) @(negedge clk_i);
    sb_q.delete();
    run_q.delete();
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    run_req("post_reset", '{32'd7, 32'd20, 1'b0, 100, 60, 1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crg_triple_streamer.md
Name: crg_triple_streamer

Overview:
- Sits directly downstream of CRG. It issues counter-range bursts to CRG, buffers the a/b/c (and e) shares that CRG returns, and serialises each triple onto a 256-bit valid/ready stream toward the MPC engine.
- Flow control is credit-based, because CRG has no backpressure input: a burst is issued only when the FIFO can absorb every result of that burst.

Parameters:
- DEPTH, 512, triple FIFO depth in entries; power of two, must be at least BURST.
- BURST, 256, maximum number of counter values per CRG run.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low; the same net drives CRG
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when both req_valid_i and req_ready_o are high
- req_cnt_start_i  in  32  first counter value (cr_cnt_t)
- req_num_i  in  32  number of triples requested
- req_ext_i  in  1  extended-mode request; e is present
- done_o  out  1  one-cycle pulse when a request has fully drained
- err_o  out  1  sticky flag: dvld_i seen with no credit outstanding
- crg_run_o  out  1  one-cycle run pulse to CRG
- crg_cnt_start_o  out  32  to CRG cnt_start_i
- crg_cnt_end_o  out  32  to CRG cnt_end_i, inclusive
- crg_a_i, crg_b_i, crg_c_i  in  256 each  share outputs from CRG (prng_t)
- crg_e_i  in  8  e share from CRG
- crg_dvld_i  in  1  CRG data valid
- m_tdata_o  out  256  stream data
- m_tuser_o  out  2  beat kind: 0 = a, 1 = b, 2 = c, 3 = e
- m_tlast_o  out  1  last beat of the request
- m_tvalid_o  out  1  stream valid
- m_tready_i  in  1  stream ready

Behaviour:
- Reset values: req_ready_o = 1; all other outputs = 0; FIFO empty; outstanding = 0.
- Reset mid-operation clears all state. CRG is reset by the same net, so no stale dvld can follow.
- CRG contract: for a run pulse with start S and end E (E ≥ S), CRG returns E−S+1 dvld cycles, one per counter value in ascending order, beginning a fixed pipeline latency after the pulse. crg_cnt_start_o and crg_cnt_end_o are held stable from the run pulse until the next run pulse.
- FSM states:
  - IDLE: req_ready_o = 1. On accept, latch cur = req_cnt_start_i, rem = req_num_i, ext = req_ext_i. Go to CREDIT if rem ≠ 0, else DRAIN.
  - CREDIT: wait until outstanding == 0 and free ≥ n, where free = DEPTH − fifo_count and n = min(BURST, rem, 2^32 − cur). The last term splits a burst at the 0xFFFFFFFF counter wrap so that E ≥ S always.
  - ISSUE: one cycle. crg_run_o = 1, start = cur, end = cur + n − 1, outstanding = n. Then cur += n (modulo 2^32) and rem −= n. Next state is CREDIT if rem ≠ 0, else DRAIN.
  - DRAIN: wait until outstanding == 0, FIFO empty and serialiser idle. Then pulse done_o, go to IDLE (req_ready_o returns high in the same cycle as done_o).
- dvld handling:
  - When crg_dvld_i = 1 and outstanding > 0: push {a, b, c, e}, outstanding −= 1.
  - When outstanding == 0: drop the data and set err_o.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- FIFO occupancy never exceeds DEPTH, because credit is reserved at issue time.
- Serialiser:
  - Pops one entry and emits beats a, b, c (plus e if enabled, see Optional Feature).
  - A beat advances only when m_tvalid_o and m_tready_i are both high. m_tdata_o, m_tuser_o and m_tlast_o hold stable while m_tvalid_o is high and m_tready_i is low.
  - An e beat carries e in bits [7:0] and zeros in [255:8].
  - m_tlast_o is asserted on the final beat of the final triple of the request.
  - Sustained throughput is one beat per cycle with no bubble between triples.
- req_num_i = 0: request accepted, no CRG run, no beats, done_o pulses 2 cycles after accept.

Optional Feature:
- Macro CRG_STREAM_E_BEAT_EN.
- Defined: when ext = 1, each triple emits 4 beats (a, b, c, e with m_tuser_o = 3).
- Undefined: e is not stored (FIFO width is 768) and every triple emits 3 beats regardless of ext. req_ext_i and crg_e_i stay as ports but are ignored.

Decomposition:
- Add to package TYPES:
  - beat_kind_t enum {BEAT_A, BEAT_B, BEAT_C, BEAT_E}
  - triple_t struct {prng_t a, b, c; logic [7:0] e}
  - streamer FSM state enum
- Reuse the existing prng_t and cr_cnt_t types.
- Sub-module: triple_fifo, a synchronous FIFO with first-word fall-through, count output and parameterised width/depth.

Test Plan:
- Basic: start = 3, num = 10, ext = 0, m_tready_i held at 1 → one run with S = 3, E = 12; 30 beats; tuser sequence 0,1,2 repeating; tlast only on beat 30; each triple's shares match the CRG outputs; done_o pulses once.
- Burst split: start = 0, num = 600, BURST = 256 → three runs (0–255, 256–511, 512–599); no run is issued while outstanding > 0; 1800 beats.
- Wrap: start = 0xFFFFFFFE, num = 5 → runs FFFFFFFE–FFFFFFFF and 0–2; 15 beats in counter order.
- Backpressure: num = 1000 with m_tready_i toggling randomly (30% high) → FIFO never overflows, tdata stable while stalled, no beat lost or duplicated, err_o stays 0.
- Extended: with CRG_STREAM_E_BEAT_EN defined, ext = 1, num = 4 → 16 beats, e beat low byte = crg_e_i, upper bits zero. Without the macro → 12 beats.
- Reset and edge cases: num = 0 → no run, done_o 2 cycles after accept. Assert rst_n_i low mid-burst → all outputs return to reset values immediately, req_ready_o = 1, and a new request then completes normally.
